onchip_copy_engine: RTL and testbench
=====================================

Name: onchip_copy_engine

Overview:
Avalon-MM block-copy/fill engine sitting directly upstream of the 1024x32 on-chip RAM. Nios writes a small CSR bank to request either a copy of N words from one RAM region to another, or a fill of N words with a constant. The engine then drives the RAM's second slave port as its only master, for example to clear or scroll the pong playfield buffer without CPU load. The RAM has a fixed 1-cycle read latency and no waitrequest; the engine relies on both.

Parameters:
ADDR_W, 10, RAM word-address width; addresses wrap modulo 2^ADDR_W
DATA_W, 32, RAM data width
LEN_W, 11, length register width; max length is 2^ADDR_W words

Ports:
clk  input  1  single clock, shared with the RAM
reset  input  1  synchronous, active-high
csr_address  input  2  0=SRC, 1=DST, 2=LEN, 3=CTRL/STATUS
csr_chipselect  input  1  CSR access select
csr_write  input  1  CSR write strobe
csr_read  input  1  CSR read strobe
csr_writedata  input  32  CSR write data
csr_readdata  output  32  CSR read data, registered, 1-cycle latency
irq  output  1  level interrupt = done & ie
mem_address  output  ADDR_W  RAM word address
mem_chipselect  output  1  RAM select
mem_write  output  1  RAM write strobe
mem_byteenable  output  DATA_W/8  always all ones when writing
mem_writedata  output  DATA_W  RAM write data
mem_clken  output  1  RAM clock enable, tied to 1
mem_readdata  input  DATA_W  RAM q, valid the cycle after the address is presented

Behaviour:
- Reset: all CSRs 0; state IDLE; csr_readdata=0; irq=0; mem_chipselect=0; mem_write=0; mem_address=0; mem_writedata=0; mem_byteenable=all ones; mem_clken=1.
- CSR map:
  - SRC[ADDR_W-1:0]: source address in copy mode; in fill mode SRC holds the full 32-bit fill pattern.
  - DST[ADDR_W-1:0]: destination address.
  - LEN[LEN_W-1:0]: word count. Values above 2^ADDR_W saturate to 2^ADDR_W.
  - CTRL write bits: bit0 START (self-clearing), bit1 MODE (0=copy, 1=fill), bit3 IE, bit4 write 1 to clear DONE.
  - STATUS read bits: bit0 BUSY, bit1 DONE, bit2 ABORTED, bit3 IE, bit1 mirror of MODE at bit5.
- CSR writes to SRC, DST or LEN while BUSY are ignored. START while BUSY is ignored. IE and DONE-clear are always honoured.
- START in IDLE does the following:
  - Latches working copies of src, dst and remaining=LEN.
  - Clears DONE and ABORTED.
  - Sets BUSY the next cycle.
  - If LEN=0, goes straight to DONE_ST with no RAM access.
- Writing CTRL bit2 (ABORT) while BUSY does the following:
  - Any RAM write issued in the current cycle completes.
  - The next cycle enters IDLE with BUSY=0, ABORTED=1, DONE=1.
- Copy FSM, 3 cycles per word:
  - RD: mem_chipselect=1, mem_write=0, mem_address=src → CAP.
  - CAP: buffer<=mem_readdata; RAM idle → WR.
  - WR: mem_chipselect=1, mem_write=1, mem_address=dst, mem_writedata=buffer. Then src+=1 and dst+=1 (mod 2^ADDR_W), remaining-=1. If remaining becomes 0 → DONE_ST, else → RD.
- Fill FSM, 1 cycle per word:
  - WR: writes pattern to dst. dst+=1, remaining-=1. If remaining becomes 0 → DONE_ST, else stay in WR.
- DONE_ST: for one cycle sets DONE=1 and BUSY=0 → IDLE.
- Overlapping regions: copy is strictly ascending. With dst=src+1 this replicates the first word, which is the defined behaviour.
- Wrap-around: src and dst wrap past 2^ADDR_W-1 to 0 with no error.
- irq tracks DONE&IE combinationally from registered bits, so it stays set until DONE is cleared or IE=0.
- Reset mid-transfer: the engine returns to IDLE in the next cycle and no further RAM write is issued.
- Simultaneous START and DONE-clear in one write: START wins and DONE ends at 0.

Test Plan:
- Fill: SRC=0xA5A5A5A5, DST=0x100, LEN=4, MODE=1, START.
  Required: exactly 4 consecutive write cycles to 0x100..0x103 with pattern 0xA5A5A5A5; DONE=1 on the 5th cycle after BUSY rises.
- Copy: preload RAM[0x010..0x012]={1,2,3}; SRC=0x010, DST=0x200, LEN=3, START.
  Required: RAM[0x200..0x202]={1,2,3}; 9 active cycles then DONE; irq=1 with IE=1; write bit4 → irq=0 next cycle.
- Wrap: fill DST=0x3FE, LEN=4.
  Required: writes to 0x3FE, 0x3FF, 0x000, 0x001 only.
- LEN=0 with START.
  Required: no mem_chipselect pulse; DONE=1 within 2 cycles.
- Abort: copy LEN=100; assert ABORT after the 10th write.
  Required: at most one further write; STATUS=ABORTED|DONE; BUSY=0.
- Writes while busy: during a copy, write SRC=0x3 and a second START.
  Required: SRC readback unchanged; the transfer completes as originally programmed.
- Reset: assert reset in a WR cycle.
  Required: mem_write=0 from the next cycle; all CSRs read 0.

Source files
------------

// File: rtl/onchip_copy_engine_if.sv
// CSR slave port plus RAM master port of the copy/fill engine, bundled as one interface.
// slave = engine view, master = system (CPU + RAM) view.
interface onchip_copy_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [1:0]          csr_address;
  logic                csr_chipselect;
  logic                csr_write;
  logic                csr_read;
  logic [31:0]         csr_writedata;
  logic [31:0]         csr_readdata;
  logic                irq;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  csr_address, csr_chipselect, csr_write, csr_read, csr_writedata, mem_readdata,
    output csr_readdata, irq, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken
  );

  modport master (
    output csr_address, csr_chipselect, csr_write, csr_read, csr_writedata, mem_readdata,
    input  csr_readdata, irq, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_copy_engine.sv
// Block copy/fill engine mastering the on-chip RAM's second port, programmed via a 4-word CSR bank.
// Latency: copy 3 cycles/word, fill 1 cycle/word, CSR read data 1 cycle after the read strobe.
// Backpressure: none; relies on the RAM's fixed 1-cycle read latency and absence of waitrequest.
module onchip_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  onchip_copy_engine_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic                mode_q, ie_q, done_q, aborted_q;
  logic [ADDR_W-1:0]   src_w_q, dst_w_q;
  logic [LEN_W-1:0]    rem_q;
  logic [DATA_W-1:0]   buf_q;
  logic [31:0]         rdata_q, rdata_d;

  logic busy, csr_wr, ctrl_wr, start, abort, finish;

  assign busy    = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_WR);
  assign csr_wr  = bus.csr_chipselect && bus.csr_write;
  assign ctrl_wr = csr_wr && (bus.csr_address == 2'd3);
  assign start   = ctrl_wr && bus.csr_writedata[0] && !busy;
  assign abort   = ctrl_wr && bus.csr_writedata[2] && busy;

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (len_q == '0) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end else begin
            state_d = bus.csr_writedata[1] ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: state_d = ST_WR;
      ST_WR: begin
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end else begin
          state_d = mode_q ? ST_WR : ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort lets the write already on the bus this cycle land, then parks the engine.
    if (abort) begin
      state_d = ST_IDLE;
      finish  = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus.csr_chipselect && bus.csr_read) begin
      case (bus.csr_address)
        2'd0:    rdata_d = src_q;
        2'd1:    rdata_d = 32'(dst_q);
        2'd2:    rdata_d = 32'(len_q);
        default: rdata_d = {26'd0, mode_q, 1'b0, ie_q, aborted_q, done_q, busy};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      src_w_q   <= '0;
      dst_w_q   <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;

      if (csr_wr && !busy) begin
        case (bus.csr_address)
          2'd0: src_q <= bus.csr_writedata;
          2'd1: dst_q <= bus.csr_writedata[ADDR_W-1:0];
          2'd2: len_q <= (bus.csr_writedata > 32'(LEN_MAX)) ? LEN_MAX
                                                            : bus.csr_writedata[LEN_W-1:0];
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        ie_q <= bus.csr_writedata[3];
        if (bus.csr_writedata[4]) done_q <= 1'b0;
        if (!busy) mode_q <= bus.csr_writedata[1];
      end

      // START is ordered after DONE-clear so that a combined write leaves DONE low.
      if (start) begin
        src_w_q   <= src_q[ADDR_W-1:0];
        dst_w_q   <= dst_q;
        rem_q     <= len_q;
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end

      if (state_q == ST_CAP) buf_q <= bus.mem_readdata;

      if (state_q == ST_WR) begin
        dst_w_q <= dst_w_q + ADDR_W'(1);
        rem_q   <= rem_q - LEN_W'(1);
        if (!mode_q) src_w_q <= src_w_q + ADDR_W'(1);
      end

      if (abort) begin
        aborted_q <= 1'b1;
        done_q    <= 1'b1;
      end else if (finish) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bus.csr_readdata   = rdata_q;
  assign bus.irq            = done_q & ie_q;
  assign bus.mem_chipselect = (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.mem_write      = (state_q == ST_WR);
  assign bus.mem_address    = (state_q == ST_RD) ? src_w_q :
                              (state_q == ST_WR) ? dst_w_q : '0;
  assign bus.mem_writedata  = (state_q != ST_WR) ? '0 :
                              mode_q ? DATA_W'(src_q) : buf_q;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_copy_engine.sv
// Directed bench for onchip_copy_engine with a behavioural 1024x32 RAM and a write scoreboard.
// Every RAM write seen on the bus is popped against the queue of writes the stimulus expects.
module tb_onchip_copy_engine;

  logic clk;
  logic reset;

  onchip_copy_engine_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  onchip_copy_engine #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: 1-cycle registered read, no waitrequest
  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      ram_q <= ram[bus.mem_address];
    end
  end
  assign bus.mem_readdata = ram_q;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_en;
  int   n_checks;
  int   n_fail;
  int   wr_cnt;
  int   cs_cnt;

  localparam logic [1:0] A_SRC = 2'd0, A_DST = 2'd1, A_LEN = 2'd2, A_CTRL = 2'd3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances to the next falling edge and scores any RAM access in that cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset && bus.mem_chipselect) begin
      cs_cnt++;
      if (bus.mem_write) begin
        wr_cnt++;
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_write", 32'(bus.mem_address), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check("wr_addr", 32'(bus.mem_address), 32'(e.a));
            check("wr_data", bus.mem_writedata, e.d);
          end
        end
      end
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    tick();
    bus.csr_chipselect = 1'b1;
    bus.csr_write      = 1'b1;
    bus.csr_address    = a;
    bus.csr_writedata  = d;
    tick();
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    tick();
    bus.csr_chipselect = 1'b1;
    bus.csr_read       = 1'b1;
    bus.csr_address    = a;
    tick();
    bus.csr_chipselect = 1'b0;
    bus.csr_read       = 1'b0;
    d = bus.csr_readdata;
  endtask

  task automatic wait_irq(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!bus.irq && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.irq), 32'd1);
  endtask

  task automatic push(input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int n;

    n_checks = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    cs_cnt   = 0;
    sb_en    = 1'b1;
    reset    = 1'b1;
    bus.csr_address    = 2'd0;
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
    bus.csr_read       = 1'b0;
    bus.csr_writedata  = 32'd0;

    for (int i = 0; i < 3; i++) tick();
    check("rst_readdata", bus.csr_readdata, 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_mem_cs", 32'(bus.mem_chipselect), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata", bus.mem_writedata, 32'd0);
    check("rst_byteenable", 32'(bus.mem_byteenable), 32'hF);
    check("rst_clken", 32'(bus.mem_clken), 32'd1);
    reset = 1'b0;

    // Fill: 4 back-to-back writes, DONE visible on the 5th cycle after BUSY rises
    for (int i = 0; i < 4; i++) push(10'h100 + 10'(i), 32'hA5A5_A5A5);
    csr_wr(A_SRC, 32'hA5A5_A5A5);
    csr_wr(A_DST, 32'h100);
    csr_wr(A_LEN, 32'd4);
    csr_wr(A_CTRL, 32'h0B);
    check("fill_c1_write", 32'(bus.mem_write), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("fill_cN_write", 32'(bus.mem_write), 32'd1);
    end
    check("fill_c4_irq", 32'(bus.irq), 32'd0);
    tick();
    check("fill_c5_irq", 32'(bus.irq), 32'd1);
    check("fill_c5_write", 32'(bus.mem_write), 32'd0);
    check("fill_sb_empty", 32'(sb_q.size()), 32'd0);
    csr_rd(A_CTRL, rd);
    check("fill_status", rd, 32'h2A);

    // Preload RAM[0x010..0x012] = {1,2,3} with single-word fills
    for (int i = 0; i < 3; i++) begin
      push(10'h010 + 10'(i), 32'(i + 1));
      csr_wr(A_SRC, 32'(i + 1));
      csr_wr(A_DST, 32'h010 + 32'(i));
      csr_wr(A_LEN, 32'd1);
      csr_wr(A_CTRL, 32'h0B);
      wait_irq("preload_done", 10);
      csr_wr(A_CTRL, 32'h18);
    end

    // Copy: 3 words, 9 active cycles, then DONE/irq
    for (int i = 0; i < 3; i++) push(10'h200 + 10'(i), 32'(i + 1));
    csr_wr(A_SRC, 32'h010);
    csr_wr(A_DST, 32'h200);
    csr_wr(A_LEN, 32'd3);
    csr_wr(A_CTRL, 32'h09);
    for (int k = 2; k <= 9; k++) tick();
    check("copy_c9_irq", 32'(bus.irq), 32'd0);
    tick();
    check("copy_c10_irq", 32'(bus.irq), 32'd1);
    check("copy_sb_empty", 32'(sb_q.size()), 32'd0);
    check("copy_ram200", ram[10'h200], 32'd1);
    check("copy_ram202", ram[10'h202], 32'd3);
    csr_rd(A_CTRL, rd);
    check("copy_status", rd, 32'h0A);
    csr_wr(A_CTRL, 32'h18);
    check("copy_irq_cleared", 32'(bus.irq), 32'd0);

    // Wrap: fill crossing the top of the address space
    push(10'h3FE, 32'h5A5A_0001);
    push(10'h3FF, 32'h5A5A_0001);
    push(10'h000, 32'h5A5A_0001);
    push(10'h001, 32'h5A5A_0001);
    base = cs_cnt;
    csr_wr(A_SRC, 32'h5A5A_0001);
    csr_wr(A_DST, 32'h3FE);
    csr_wr(A_LEN, 32'd4);
    csr_wr(A_CTRL, 32'h0B);
    wait_irq("wrap_done", 20);
    check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
    check("wrap_access_count", 32'(cs_cnt - base), 32'd4);

    // LEN saturation, then LEN=0 completes without touching the RAM
    csr_wr(A_LEN, 32'h7FF);
    csr_rd(A_LEN, rd);
    check("len_saturate", rd, 32'h400);
    csr_wr(A_LEN, 32'd0);
    base = cs_cnt;
    csr_wr(A_CTRL, 32'h09);
    if (!bus.irq) tick();
    check("len0_done", 32'(bus.irq), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("len0_no_access", 32'(cs_cnt - base), 32'd0);

    // Abort a long copy after its 10th write
    sb_en = 1'b0;
    csr_wr(A_SRC, 32'h000);
    csr_wr(A_DST, 32'h300);
    csr_wr(A_LEN, 32'd100);
    base = wr_cnt;
    csr_wr(A_CTRL, 32'h09);
    n = 0;
    while ((wr_cnt - base) < 10 && n < 400) begin
      tick();
      n++;
    end
    check("abort_reach_10", 32'(wr_cnt - base), 32'd10);
    csr_wr(A_CTRL, 32'h0C);
    for (int i = 0; i < 6; i++) tick();
    check("abort_extra_writes", 32'((wr_cnt - base) <= 11), 32'd1);
    csr_rd(A_CTRL, rd);
    check("abort_status", rd, 32'h0E);
    sb_en = 1'b1;

    // SRC write and second START while busy are ignored
    for (int i = 0; i < 3; i++) push(10'h210 + 10'(i), 32'(i + 1));
    csr_wr(A_SRC, 32'h010);
    csr_wr(A_DST, 32'h210);
    csr_wr(A_LEN, 32'd3);
    csr_wr(A_CTRL, 32'h09);
    csr_wr(A_SRC, 32'h003);
    csr_wr(A_CTRL, 32'h09);
    wait_irq("busy_wr_done", 40);
    for (int i = 0; i < 4; i++) tick();
    check("busy_sb_empty", 32'(sb_q.size()), 32'd0);
    csr_rd(A_SRC, rd);
    check("busy_src_kept", rd, 32'h010);

    // Reset during a fill write cycle
    sb_en = 1'b0;
    csr_wr(A_SRC, 32'h1234_5678);
    csr_wr(A_DST, 32'h080);
    csr_wr(A_LEN, 32'd8);
    csr_wr(A_CTRL, 32'h0B);
    n = 0;
    while (!bus.mem_write && n < 10) begin
      tick();
      n++;
    end
    check("rst_in_wr_cycle", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_write", 32'(bus.mem_write), 32'd0);
    check("rst_mid_cs", 32'(bus.mem_chipselect), 32'd0);
    reset = 1'b0;
    base = wr_cnt;
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), rd);
      check("rst_csr_zero", rd, 32'd0);
    end
    check("rst_no_writes", 32'(wr_cnt - base), 32'd0);
    check("rst_irq_low", 32'(bus.irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
